reg_writeback_arbiter: RTL and testbench

//   Write-port driver for the 8x8 register file: merges ALU results and load-unit results into the

---
 rtl/reg_writeback_arbiter.sv | 148 ++++++++++++++
 tb/tb_reg_writeback_arbiter.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/reg_writeback_arbiter.sv
// Register-file write-port driver: ALU results take the port unconditionally and
// load results wait in a small FIFO. Loads that an ALU write overtakes (WAW) are dropped.
module reg_writeback_arbiter #(
  parameter int unsigned DW       = 8,
  parameter int unsigned AW       = 3,
  parameter int unsigned LQ_DEPTH = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  alu_valid,
  input  logic [AW-1:0]         alu_reg,
  input  logic [DW-1:0]         alu_data,
  input  logic                  ld_valid,
  output logic                  ld_ready,
  input  logic [AW-1:0]         ld_reg,
  input  logic [DW-1:0]         ld_data,
  output logic                  regWrite,
  output logic [AW-1:0]         writeReg,
  output logic [DW-1:0]         writeData,
  output logic [(1<<AW)-1:0]    pend_mask,
  output logic [7:0]            kill_cnt,
  output logic                  idle
);

  localparam int unsigned PW = $clog2(LQ_DEPTH);
  localparam int unsigned CW = $clog2(LQ_DEPTH + 1);
  localparam int unsigned NR = 1 << AW;

  logic [LQ_DEPTH-1:0] live_q, live_d;
  logic [AW-1:0]       reg_q  [LQ_DEPTH];
  logic [AW-1:0]       reg_d  [LQ_DEPTH];
  logic [DW-1:0]       data_q [LQ_DEPTH];
  logic [DW-1:0]       data_d [LQ_DEPTH];
  logic [PW-1:0]       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic                we_q, we_d;
  logic [AW-1:0]       wreg_q, wreg_d;
  logic [DW-1:0]       wdata_q, wdata_d;
  logic [NR-1:0]       pend_q, pend_d;
  logic [7:0]          kill_q, kill_d;
  logic                ready_q, ready_d;
  logic                idle_q, idle_d;
  logic                push, pop, present;
  logic [CW-1:0]       kill_n;
  logic [8:0]          kill_sum;

  // Selection, WAW kill and queue update. Slots outside the live window always
  // hold live=0, so the kill and pending scans need no occupancy check.
  always_comb begin
    live_d   = live_q;
    reg_d    = reg_q;
    data_d   = data_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    we_d     = 1'b0;
    wreg_d   = wreg_q;
    wdata_d  = wdata_q;
    kill_n   = '0;
    pend_d   = '0;
    push     = ld_valid & ready_q;
    present  = (cnt_q != '0);
    pop      = ~alu_valid & present;

    for (int i = 0; i < LQ_DEPTH; i++) begin
      if (alu_valid && live_q[i] && (reg_q[i] == alu_reg)) begin
        live_d[i] = 1'b0;
        kill_n    = kill_n + CW'(1);
      end
    end

    if (alu_valid) begin
      we_d    = 1'b1;
      wreg_d  = alu_reg;
      wdata_d = alu_data;
    end else if (present) begin
      if (live_q[rd_ptr_q]) begin
        we_d    = 1'b1;
        wreg_d  = reg_q[rd_ptr_q];
        wdata_d = data_q[rd_ptr_q];
      end
      live_d[rd_ptr_q] = 1'b0;
      rd_ptr_d         = rd_ptr_q + PW'(1);
    end

    // The accepted load is younger than this cycle's ALU result, so it is written after the kill scan.
    if (push) begin
      live_d[wr_ptr_q] = 1'b1;
      reg_d[wr_ptr_q]  = ld_reg;
      data_d[wr_ptr_q] = ld_data;
      wr_ptr_d         = wr_ptr_q + PW'(1);
    end

    cnt_d    = cnt_q + CW'(push) - CW'(pop);
    kill_sum = {1'b0, kill_q} + 9'(kill_n);
    kill_d   = kill_sum[8] ? 8'hFF : kill_sum[7:0];
    ready_d  = (cnt_d != CW'(LQ_DEPTH));
    idle_d   = (cnt_d == '0) & ~we_d;

    for (int i = 0; i < LQ_DEPTH; i++) begin
      if (live_d[i]) pend_d[reg_d[i]] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      live_q   <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      we_q     <= 1'b0;
      wreg_q   <= '0;
      wdata_q  <= '0;
      pend_q   <= '0;
      kill_q   <= '0;
      ready_q  <= 1'b1;
      idle_q   <= 1'b1;
      for (int i = 0; i < LQ_DEPTH; i++) begin
        reg_q[i]  <= '0;
        data_q[i] <= '0;
      end
    end else begin
      live_q   <= live_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      we_q     <= we_d;
      wreg_q   <= wreg_d;
      wdata_q  <= wdata_d;
      pend_q   <= pend_d;
      kill_q   <= kill_d;
      ready_q  <= ready_d;
      idle_q   <= idle_d;
      for (int i = 0; i < LQ_DEPTH; i++) begin
        reg_q[i]  <= reg_d[i];
        data_q[i] <= data_d[i];
      end
    end
  end

  assign ld_ready  = ready_q;
  assign regWrite  = we_q;
  assign writeReg  = wreg_q;
  assign writeData = wdata_q;
  assign pend_mask = pend_q;
  assign kill_cnt  = kill_q;
  assign idle      = idle_q;

endmodule

// File: tb/tb_reg_writeback_arbiter.sv
// Directed bench for reg_writeback_arbiter: hand-computed write-port, pending-mask,
// ready, idle and kill-count values after each clock edge.
module tb_reg_writeback_arbiter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       alu_valid;
  logic [2:0] alu_reg;
  logic [7:0] alu_data;
  logic       ld_valid;
  logic       ld_ready;
  logic [2:0] ld_reg;
  logic [7:0] ld_data;
  logic       regWrite;
  logic [2:0] writeReg;
  logic [7:0] writeData;
  logic [7:0] pend_mask;
  logic [7:0] kill_cnt;
  logic       idle;

  int n_checks = 0;
  int n_errors = 0;

  reg_writeback_arbiter #(.DW(8), .AW(3), .LQ_DEPTH(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .alu_valid (alu_valid),
    .alu_reg   (alu_reg),
    .alu_data  (alu_data),
    .ld_valid  (ld_valid),
    .ld_ready  (ld_ready),
    .ld_reg    (ld_reg),
    .ld_data   (ld_data),
    .regWrite  (regWrite),
    .writeReg  (writeReg),
    .writeData (writeData),
    .pend_mask (pend_mask),
    .kill_cnt  (kill_cnt),
    .idle      (idle)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic av, input logic [2:0] ar, input logic [7:0] ad,
                       input logic lv, input logic [2:0] lr, input logic [7:0] ldat);
    alu_valid = av; alu_reg = ar; alu_data = ad;
    ld_valid  = lv; ld_reg  = lr; ld_data  = ldat;
  endtask

  task automatic expect_port(input string tag, input logic we, input logic [2:0] r,
                             input logic [7:0] d, input logic [7:0] pm);
    check({tag, ".regWrite"},  32'(regWrite),  32'(we));
    check({tag, ".writeReg"},  32'(writeReg),  32'(r));
    check({tag, ".writeData"}, 32'(writeData), 32'(d));
    check({tag, ".pend_mask"}, 32'(pend_mask), 32'(pm));
  endtask

  initial begin
    rst_n = 1'b0;
    drive(1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 8'h00);
    tick;
    tick;
    expect_port("reset", 1'b0, 3'd0, 8'h00, 8'h00);
    check("reset.kill_cnt", 32'(kill_cnt), 32'd0);
    check("reset.ld_ready", 32'(ld_ready), 32'd1);
    check("reset.idle",     32'(idle),     32'd1);
    rst_n = 1'b1;
    tick;

    // 1: single ALU write, one-cycle pulse, address/data hold afterwards
    drive(1'b1, 3'd3, 8'h5A, 1'b0, 3'd0, 8'h00);
    tick;
    drive(1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 8'h00);
    expect_port("t1.write", 1'b1, 3'd3, 8'h5A, 8'h00);
    check("t1.idle_busy", 32'(idle), 32'd0);
    tick;
    expect_port("t1.after", 1'b0, 3'd3, 8'h5A, 8'h00);
    check("t1.idle", 32'(idle), 32'd1);

    // 2: back-to-back loads drain in order
    drive(1'b0, 3'd0, 8'h00, 1'b1, 3'd1, 8'h11);
    tick;
    expect_port("t2.enq1", 1'b0, 3'd3, 8'h5A, 8'h02);
    drive(1'b0, 3'd0, 8'h00, 1'b1, 3'd2, 8'h22);
    tick;
    drive(1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 8'h00);
    expect_port("t2.wr1", 1'b1, 3'd1, 8'h11, 8'h04);
    tick;
    expect_port("t2.wr2", 1'b1, 3'd2, 8'h22, 8'h00);
    tick;
    check("t2.done", 32'(regWrite), 32'd0);
    check("t2.idle", 32'(idle), 32'd1);

    // 3: ALU holds the port for 3 cycles while the queue fills
    drive(1'b1, 3'd6, 8'h61, 1'b1, 3'd1, 8'h31);
    tick;
    expect_port("t3.alu0", 1'b1, 3'd6, 8'h61, 8'h02);
    check("t3.ready0", 32'(ld_ready), 32'd1);
    drive(1'b1, 3'd7, 8'h62, 1'b1, 3'd2, 8'h32);
    tick;
    expect_port("t3.alu1", 1'b1, 3'd7, 8'h62, 8'h06);
    check("t3.full", 32'(ld_ready), 32'd0);
    drive(1'b1, 3'd0, 8'h63, 1'b1, 3'd3, 8'h33);
    tick;
    drive(1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 8'h00);
    expect_port("t3.alu2", 1'b1, 3'd0, 8'h63, 8'h06);
    check("t3.still_full", 32'(ld_ready), 32'd0);
    tick;
    expect_port("t3.ld1", 1'b1, 3'd1, 8'h31, 8'h04);
    check("t3.ready_back", 32'(ld_ready), 32'd1);
    tick;
    expect_port("t3.ld2", 1'b1, 3'd2, 8'h32, 8'h00);
    tick;
    expect_port("t3.drained", 1'b0, 3'd2, 8'h32, 8'h00);
    check("t3.kill_cnt", 32'(kill_cnt), 32'd0);

    // 4: queued load overtaken by ALU write to the same register
    drive(1'b0, 3'd0, 8'h00, 1'b1, 3'd4, 8'hAA);
    tick;
    expect_port("t4.enq", 1'b0, 3'd2, 8'h32, 8'h10);
    drive(1'b1, 3'd4, 8'hBB, 1'b0, 3'd0, 8'h00);
    tick;
    drive(1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 8'h00);
    expect_port("t4.alu", 1'b1, 3'd4, 8'hBB, 8'h00);
    check("t4.kill_cnt", 32'(kill_cnt), 32'd1);
    tick;
    expect_port("t4.dead", 1'b0, 3'd4, 8'hBB, 8'h00);
    check("t4.idle", 32'(idle), 32'd1);
    tick;
    expect_port("t4.quiet", 1'b0, 3'd4, 8'hBB, 8'h00);

    // 5: same-cycle ALU and load to r5: load is younger and survives
    drive(1'b1, 3'd5, 8'h55, 1'b1, 3'd5, 8'hCC);
    tick;
    drive(1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 8'h00);
    expect_port("t5.alu", 1'b1, 3'd5, 8'h55, 8'h20);
    tick;
    expect_port("t5.ld", 1'b1, 3'd5, 8'hCC, 8'h00);
    check("t5.kill_cnt", 32'(kill_cnt), 32'd1);

    // 6: async reset with two loads queued discards them
    drive(1'b1, 3'd6, 8'h01, 1'b1, 3'd1, 8'h71);
    tick;
    drive(1'b1, 3'd6, 8'h02, 1'b1, 3'd2, 8'h72);
    tick;
    drive(1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 8'h00);
    check("t6.pre_pend",  32'(pend_mask), 32'h06);
    check("t6.pre_ready", 32'(ld_ready),  32'd0);
    #2;
    rst_n = 1'b0;
    #1;
    expect_port("t6.rst", 1'b0, 3'd0, 8'h00, 8'h00);
    check("t6.rst_ready", 32'(ld_ready), 32'd1);
    check("t6.rst_idle",  32'(idle),     32'd1);
    check("t6.rst_kill",  32'(kill_cnt), 32'd0);
    tick;
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick;
      expect_port("t6.post", 1'b0, 3'd0, 8'h00, 8'h00);
    end
    check("t6.post_idle", 32'(idle), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
